mem_port_arbiter: RTL

Two-requester round-robin arbiter that serialises the read and write traffic of core 0 and core 1 cache controllers onto one single-port main-memory interface. It latches the winning request, drives the memory for a fixed MEM_LAT-cycle access, and returns read data with a one-cycle ack. The arbiter replaces the dual direct write ports, so simultaneous writebacks can no longer collide in the same cycle.

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache-controller request ports, their completion
// signals and the single-port main-memory interface served by
// mem_port_arbiter.
//   master : cores and memory model (drive requests and mem_rdata)
//   slave  : the arbiter
interface mem_port_arbiter_if #(
   parameter int unsigned MEM_ADDR_BITS = 6,
   parameter int unsigned DATA_BITS     = 8
);
   // core 0 request port
   logic                     req_0;
   logic                     we_0;
   logic [MEM_ADDR_BITS-1:0] addr_0;
   logic [DATA_BITS-1:0]     wdata_0;
   logic                     grant_0;
   logic                     ack_0;
   logic [DATA_BITS-1:0]     rdata_0;

   // core 1 request port
   logic                     req_1;
   logic                     we_1;
   logic [MEM_ADDR_BITS-1:0] addr_1;
   logic [DATA_BITS-1:0]     wdata_1;
   logic                     grant_1;
   logic                     ack_1;
   logic [DATA_BITS-1:0]     rdata_1;

   // shared main-memory port
   logic                     mem_en;
   logic                     mem_we;
   logic [MEM_ADDR_BITS-1:0] mem_addr;
   logic [DATA_BITS-1:0]     mem_wdata;
   logic [DATA_BITS-1:0]     mem_rdata;

   // statistics
   logic [7:0]               conflict_cnt;

   modport master (
      output req_0, we_0, addr_0, wdata_0,
      output req_1, we_1, addr_1, wdata_1,
      output mem_rdata,
      input  grant_0, ack_0, rdata_0,
      input  grant_1, ack_1, rdata_1,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  conflict_cnt
   );

   modport slave (
      input  req_0, we_0, addr_0, wdata_0,
      input  req_1, we_1, addr_1, wdata_1,
      input  mem_rdata,
      output grant_0, ack_0, rdata_0,
      output grant_1, ack_1, rdata_1,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output conflict_cnt
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter serialising core 0 / core 1 reads and
// writes onto one single-port main memory. Each transaction occupies
// IDLE(arbitrate) -> ACCESS x MEM_LAT -> DONE(ack). The port just acked is
// masked for one IDLE cycle so a registered requester can drop req without
// issuing a duplicate access. All outputs come from registered state.
module mem_port_arbiter #(
   parameter int unsigned MEM_ADDR_BITS = 6,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned MEM_LAT       = 2   // legal range 1..15
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e                   state_q,    state_d;
   logic                     owner_q,    owner_d;     // 0 = core 0, 1 = core 1
   logic                     we_q,       we_d;
   logic [MEM_ADDR_BITS-1:0] addr_q,     addr_d;
   logic [DATA_BITS-1:0]     wdata_q,    wdata_d;
   logic [3:0]               cnt_q,      cnt_d;
   logic                     rr_last_q,  rr_last_d;
   logic [1:0]               mask_q,     mask_d;      // bit x masks core x
   logic [DATA_BITS-1:0]     rdata0_q,   rdata0_d;
   logic [DATA_BITS-1:0]     rdata1_q,   rdata1_d;
   logic [7:0]               conflict_q, conflict_d;

   logic [1:0]               elig;
   logic                     win;

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rr_last_q  <= 1'b1;
         mask_q     <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         conflict_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rr_last_q  <= rr_last_d;
         mask_q     <= mask_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         conflict_q <= conflict_d;
      end
   end

   // Arbitration, access countdown, read capture and next-state decode.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rr_last_d  = rr_last_q;
      mask_d     = '0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      conflict_d = conflict_q;
      elig       = {bus.req_1 & ~mask_q[1], bus.req_0 & ~mask_q[0]};
      win        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (elig != 2'b00) begin
               if (elig == 2'b11) begin
                  win = ~rr_last_q;
                  if (conflict_q != 8'hFF) begin
                     conflict_d = conflict_q + 8'd1;
                  end
               end else begin
                  win = elig[1];
               end
               owner_d   = win;
               we_d      = win ? bus.we_1    : bus.we_0;
               addr_d    = win ? bus.addr_1  : bus.addr_0;
               wdata_d   = win ? bus.wdata_1 : bus.wdata_0;
               cnt_d     = CNT_INIT;
               rr_last_d = win;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!we_q) begin
                  if (owner_q) begin
                     rdata1_d = bus.mem_rdata;
                  end else begin
                     rdata0_d = bus.mem_rdata;
                  end
               end
               state_d = DONE;
            end
         end
         DONE: begin
            mask_d  = owner_q ? 2'b10 : 2'b01;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from registered state only; the write strobe is limited
   // to the first ACCESS cycle, which is when cnt still holds its load value.
   always_comb begin
      bus.grant_0      = (state_q == ACCESS) && !owner_q;
      bus.grant_1      = (state_q == ACCESS) &&  owner_q;
      bus.ack_0        = (state_q == DONE)   && !owner_q;
      bus.ack_1        = (state_q == DONE)   &&  owner_q;
      bus.mem_en       = (state_q == ACCESS);
      bus.mem_we       = (state_q == ACCESS) && we_q && (cnt_q == CNT_INIT);
      bus.mem_addr     = (state_q == ACCESS) ? addr_q  : '0;
      bus.mem_wdata    = (state_q == ACCESS) ? wdata_q : '0;
      bus.rdata_0      = rdata0_q;
      bus.rdata_1      = rdata1_q;
      bus.conflict_cnt = conflict_q;
   end

endmodule
